// File: rtl/mem_ctrl_if.sv
// CPU-side request/response and byte-wide RAM bus bundle for mem_ctrl.
// master = core/top-level side, slave = the controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial fetch/load/store controller: N-byte read done in cycle N+2, write done in N+1; rdy=0 freezes.
// Define MEM_CTRL_IO_STALL_EN to hold IO-region store bytes while io_buffer_full is high.
module mem_ctrl #(
  parameter int         ADDR_W  = 32,
  parameter logic [1:0] IO_BASE = 2'b11
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      clear,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cur_addr;
  logic              fetch_op;
  logic [2:0]        nbytes;
  logic [2:0]        issue_cnt;
  logic [2:0]        cap_cnt;
  logic              pend;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [31:0]       word;
  logic              if_done_q, ls_done_q;
  logic [31:0]       if_data_q, ls_rdata_q;
  logic              accept_ls, accept_if;
  logic              issue, capture, finish;
  logic              io_stall;
  logic [7:0]        wbyte;
  logic [2:0]        size_dec;

  assign cur_addr = base + ADDR_W'(issue_cnt);
  assign wbyte    = wdata[{issue_cnt[1:0], 3'b000} +: 8];
  assign size_dec = (bus.ls_size == 2'd0) ? 3'd1 :
                    (bus.ls_size == 2'd1) ? 3'd2 : 3'd4;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_stall = (cur_addr[17:16] == IO_BASE) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full & (cur_addr[17:16] == IO_BASE);
  assign io_stall  = 1'b0;
`endif

  // Byte arriving on mem_din merged into the partially assembled word.
  always_comb begin
    word = rbuf;
    word[{cap_cnt[1:0], 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    state_nx     = state;
    accept_ls    = 1'b0;
    accept_if    = 1'b0;
    issue        = 1'b0;
    capture      = 1'b0;
    finish       = 1'b0;
    bus.mem_a    = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = '0;
    case (state)
      IDLE: begin
        // No new request in a done cycle, so a requester still holding req is not re-served.
        if (rdy && !clear && !if_done_q && !ls_done_q) begin
          if (bus.ls_req) begin
            accept_ls = 1'b1;
            state_nx  = bus.ls_we ? WRITE : READ;
          end else if (bus.if_req) begin
            accept_if = 1'b1;
            state_nx  = READ;
          end
        end
      end
      READ: begin
        bus.mem_a = cur_addr;
        if (rdy) begin
          if (clear) begin
            state_nx = IDLE;
          end else begin
            issue   = (issue_cnt != nbytes);
            capture = pend;
            if (pend && (cap_cnt == nbytes - 3'd1)) begin
              finish   = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      WRITE: begin
        bus.mem_a = cur_addr;
        if (rdy && !io_stall) begin
          bus.mem_wr   = 1'b1;
          bus.mem_dout = wbyte;
          issue        = 1'b1;
          if (issue_cnt == nbytes - 3'd1) begin
            finish   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      fetch_op   <= 1'b0;
      nbytes     <= '0;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      pend       <= 1'b0;
      wdata      <= '0;
      rbuf       <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (!rdy) begin
      // The in-flight read byte is dropped; re-issue from the oldest uncaptured byte.
      if (state == READ) issue_cnt <= cap_cnt;
      pend <= 1'b0;
    end else begin
      state     <= state_nx;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      pend      <= issue && (state == READ);
      if (accept_ls || accept_if) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
        rbuf      <= '0;
        fetch_op  <= accept_if;
        base      <= accept_ls ? bus.ls_addr : bus.if_addr;
        wdata     <= bus.ls_wdata;
        nbytes    <= accept_if ? 3'd4 : size_dec;
      end
      if (issue) issue_cnt <= issue_cnt + 3'd1;
      if (capture) begin
        rbuf    <= word;
        cap_cnt <= cap_cnt + 3'd1;
      end
      if (finish) begin
        if (state == WRITE) begin
          ls_done_q <= 1'b1;
        end else if (fetch_op) begin
          if_done_q <= 1'b1;
          if_data_q <= word;
        end else begin
          ls_done_q  <= 1'b1;
          ls_rdata_q <= word;
        end
      end
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: transaction table plus hand-written multi-cycle corner sequences.
// Cycle 0 is the cycle a request is first presented; inputs change at posedge+1, outputs sampled at negedge.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;
  logic io_buffer_full;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // RAM model: 1 KiB aliased, read data valid the cycle after the address.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h010] <= 8'h13; ram[10'h011] <= 8'h00; ram[10'h012] <= 8'h00; ram[10'h013] <= 8'h93;
      ram[10'h020] <= 8'h7F;
      ram[10'h040] <= 8'h11; ram[10'h041] <= 8'h22; ram[10'h042] <= 8'h33; ram[10'h043] <= 8'h44;
      ram[10'h106] <= 8'h55; ram[10'h107] <= 8'h66;
      ram[10'h3FE] <= 8'h9A; ram[10'h3FF] <= 8'hAB; ram[10'h000] <= 8'hCD; ram[10'h001] <= 8'hEF;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[9:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic [31:0] exp_data;
  } txn_t;

  txn_t vec [12];

  task automatic run_txn(input int idx, input txn_t t);
    int   n;
    bit   got;
    logic dn;
    logic [31:0] dat;
    n = (t.fetch || t.size >= 2'd2) ? 4 : int'(t.size) + 1;
    if (t.fetch) begin
      bus.if_req = 1'b1; bus.if_addr = t.addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_we = t.we; bus.ls_size = t.size;
      bus.ls_addr = t.addr; bus.ls_wdata = t.wdata;
    end
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (t.we && !t.fetch && c >= 1 && c <= n) begin
        chk($sformatf("v%0d c%0d mem_wr", idx, c), 32'(bus.mem_wr), 32'd1);
        chk($sformatf("v%0d c%0d mem_a", idx, c), bus.mem_a, t.addr + 32'(c - 1));
        chk($sformatf("v%0d c%0d mem_dout", idx, c), 32'(bus.mem_dout), 32'(8'(t.wdata >> (8 * (c - 1)))));
      end else begin
        chk($sformatf("v%0d c%0d mem_wr idle", idx, c), 32'(bus.mem_wr), 32'd0);
      end
      if ((t.fetch || !t.we) && c >= 1 && c <= n)
        chk($sformatf("v%0d c%0d read mem_a", idx, c), bus.mem_a, t.addr + 32'(c - 1));
      dn  = t.fetch ? bus.if_done : bus.ls_done;
      dat = t.fetch ? bus.if_data : bus.ls_rdata;
      if (dn) begin
        got = 1'b1;
        chk($sformatf("v%0d done cycle", idx), 32'(c), 32'(t.exp_cyc));
        if (t.fetch || !t.we) chk($sformatf("v%0d data", idx), dat, t.exp_data);
      end
    end
    chk($sformatf("v%0d done seen", idx), 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int ls_c, if_c, wr_c, if_cnt;
  logic [31:0] ls_d, if_d, wr_a, wr_d;
  bit wr_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0,          6, 32'h9300_0013};
    vec[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0104, 32'h0000_BEEF, 3, 32'h0};
    vec[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0104, 32'h0,          6, 32'h6655_BEEF};
    vec[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0042, 32'h0,          3, 32'h0000_0033};
    vec[4]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0041, 32'h0,          4, 32'h0000_3322};
    vec[5]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0040, 32'h0,          6, 32'h4433_2211};
    vec[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 5, 32'h0};
    vec[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,          6, 32'hDEAD_BEEF};
    vec[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0300, 32'h1234_5678, 2, 32'h0};
    vec[9]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,          6, 32'h0000_0078};
    vec[10] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,          4, 32'h0000_CDAB};
    vec[11] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,          6, 32'hEFCD_AB9A};

    rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset if_done", 32'(bus.if_done), 32'd0);
    chk("reset ls_done", 32'(bus.ls_done), 32'd0);
    chk("reset if_data", bus.if_data, 32'd0);
    chk("reset ls_rdata", bus.ls_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_txn(i, vec[i]);

    // Simultaneous fetch and load: load wins, fetch accepted the cycle after ls_done.
    ls_c = -1; if_c = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h20;
    for (int c = 0; c < 14; c++) begin
      if (ls_c >= 0) bus.ls_req = 1'b0;
      if (if_c >= 0) bus.if_req = 1'b0;
      @(negedge clk);
      if (bus.ls_done) begin ls_c = c; ls_d = bus.ls_rdata; end
      if (bus.if_done) begin if_c = c; if_d = bus.if_data; end
      if (c == 5) chk("arb fetch mem_a c5", bus.mem_a, 32'h10);
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("arb ls_done cycle", 32'(ls_c), 32'd3);
    chk("arb ls_rdata", ls_d, 32'h0000_007F);
    chk("arb if_done cycle", 32'(if_c), 32'd10);
    chk("arb if_data", if_d, 32'h9300_0013);
    @(posedge clk); #1;

    // clear in cycle 3 of a fetch aborts it; re-request in cycle 4.
    if_c = -1; if_cnt = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    for (int c = 0; c < 14; c++) begin
      clear = (c == 3);
      if (c == 4) bus.if_addr = 32'h10;
      if (if_c >= 0) bus.if_req = 1'b0;
      @(negedge clk);
      if (bus.if_done) begin if_c = c; if_d = bus.if_data; if_cnt++; end
      if (c == 5) chk("clear refetch mem_a c5", bus.mem_a, 32'h10);
      @(posedge clk); #1;
    end
    clear = 1'b0; bus.if_req = 1'b0;
    chk("clear if_done cycle", 32'(if_c), 32'd10);
    chk("clear if_done pulses", 32'(if_cnt), 32'd1);
    chk("clear if_data", if_d, 32'h9300_0013);
    @(posedge clk); #1;

    // rdy low in cycles 2-4 of a 4-byte load.
    ls_c = -1; wr_seen = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h40;
    for (int c = 0; c < 16; c++) begin
      rdy = !(c >= 2 && c <= 4);
      if (ls_c >= 0) bus.ls_req = 1'b0;
      @(negedge clk);
      if (bus.mem_wr) wr_seen = 1'b1;
      if (bus.ls_done) begin ls_c = c; ls_d = bus.ls_rdata; end
      @(posedge clk); #1;
    end
    rdy = 1'b1; bus.ls_req = 1'b0;
    chk("stall ls_done cycle", 32'(ls_c), 32'd10);
    chk("stall ls_rdata", ls_d, 32'h4433_2211);
    chk("stall no mem_wr", 32'(wr_seen), 32'd0);
    @(posedge clk); #1;

    // IO store with io_buffer_full high in cycles 0-5.
    ls_c = -1; wr_c = -1; wr_a = '0; wr_d = '0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0;
    bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h41;
    for (int c = 0; c < 12; c++) begin
      io_buffer_full = (c <= 5);
      if (ls_c >= 0) bus.ls_req = 1'b0;
      @(negedge clk);
      if (bus.mem_wr && wr_c < 0) begin wr_c = c; wr_a = bus.mem_a; wr_d = 32'(bus.mem_dout); end
      if (bus.ls_done) ls_c = c;
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0; bus.ls_req = 1'b0;
`ifdef MEM_CTRL_IO_STALL_EN
    chk("io first mem_wr cycle", 32'(wr_c), 32'd6);
    chk("io ls_done cycle", 32'(ls_c), 32'd7);
`else
    chk("io first mem_wr cycle", 32'(wr_c), 32'd1);
    chk("io ls_done cycle", 32'(ls_c), 32'd2);
`endif
    chk("io mem_a", wr_a, 32'h0003_0000);
    chk("io mem_dout", wr_d, 32'h41);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a 4-byte store.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'h0102_0304;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("rst pre mem_wr", 32'(bus.mem_wr), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst mem_a", bus.mem_a, 32'd0);
        chk("rst mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst if_done", 32'(bus.if_done), 32'd0);
        chk("rst if_data", bus.if_data, 32'd0);
        chk("rst ls_rdata", bus.ls_rdata, 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.ls_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post rst c%0d mem_wr", c), 32'(bus.mem_wr), 32'd0);
      chk($sformatf("post rst c%0d ls_done", c), 32'(bus.ls_done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
